// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: positions a rectangle for the draw stage. It follows the
// mouse while tracking; a left click drops it under constant gravity
// (one physics step per frame) with lossy bounces off the floor.
module draw_rect_ctl #(
   parameter int SCREEN_H = 600,
   parameter int RECT_H   = 64,
   parameter int G        = 1,
   parameter int VMIN     = 2
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   input  logic        vsync_in,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        busy
);

   localparam logic [11:0] FLOOR  = 12'(SCREEN_H - RECT_H);
   localparam logic [11:0] G12    = 12'(G);
   localparam logic [11:0] VMIN12 = 12'(VMIN);

   typedef enum logic [1:0] {TRACK, FALL, RISE, STOP} state_t;

   state_t      state;
   logic [11:0] v;
   logic        vsync_prev;
   logic        left_prev;
   logic        rst_d;
   logic        tick;
   logic        click;

   logic [12:0] vn_sum;
   logic [11:0] vn;
   logic [12:0] fall_sum;
   logic        hit;
   logic [11:0] vb;
   logic [11:0] rise_y;
   logic [11:0] track_y;

   // Edge-detect registers; rst_d masks the first cycle after reset so a
   // level already high at release is not taken as an edge.
   always_ff @(posedge pclk) begin
      rst_d <= rst;
      if (rst) begin
         vsync_prev <= 1'b0;
         left_prev  <= 1'b0;
      end else begin
         vsync_prev <= vsync_in;
         left_prev  <= mouse_left;
      end
   end

   assign tick  = vsync_in   & ~vsync_prev & ~rst_d;
   assign click = mouse_left & ~left_prev  & ~rst_d;

   // Per-frame physics arithmetic and mouse clamp.
   always_comb begin
      vn_sum   = {1'b0, v} + {1'b0, G12};
      vn       = vn_sum[12] ? '1 : vn_sum[11:0];
      fall_sum = {1'b0, ypos} + {1'b0, vn};
      hit      = (fall_sum >= {1'b0, FLOOR});
      vb       = vn - (vn >> 2);
      rise_y   = (ypos > v) ? (ypos - v) : '0;
      track_y  = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
   end

   // Motion FSM with registered outputs; busy follows the state being entered.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state <= TRACK;
         v     <= '0;
         xpos  <= '0;
         ypos  <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            TRACK: begin
               v <= '0;
               if (click) begin
                  state <= FALL;
                  busy  <= 1'b1;
               end else begin
                  xpos <= mouse_xpos;
                  ypos <= track_y;
                  busy <= 1'b0;
               end
            end
            FALL: begin
               if (tick) begin
                  if (hit) begin
                     ypos <= FLOOR;
                     if (vb < VMIN12) begin
                        v     <= '0;
                        state <= STOP;
                        busy  <= 1'b0;
                     end else begin
                        v     <= vb;
                        state <= RISE;
                        busy  <= 1'b1;
                     end
                  end else begin
                     ypos <= fall_sum[11:0];
                     v    <= vn;
                  end
               end
            end
            RISE: begin
               if (tick) begin
                  if (v <= G12) begin
                     v     <= '0;
                     state <= FALL;
                     busy  <= 1'b1;
                  end else begin
                     ypos <= rise_y;
                     v    <= v - G12;
                  end
               end
            end
            STOP: begin
               if (click) begin
                  state <= TRACK;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= TRACK;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// tb_draw_rect_ctl: directed, self-checking bench for draw_rect_ctl.
module tb_draw_rect_ctl;

   logic        pclk = 1'b0;
   logic        rst;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic        mouse_left;
   logic        vsync_in;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] mx;
      logic [11:0] my;
      logic [11:0] ex;
      logic [11:0] ey;
   } trk_vec_t;

   trk_vec_t tv [8];

   draw_rect_ctl #(.SCREEN_H(600), .RECT_H(64), .G(1), .VMIN(2)) dut (
      .pclk       (pclk),
      .rst        (rst),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .mouse_left (mouse_left),
      .vsync_in   (vsync_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .busy       (busy)
   );

   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic do_tick();
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      step();
   endtask

   task automatic do_click();
      mouse_left = 1'b1;
      step();
      mouse_left = 1'b0;
      step();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      vsync_in   = 1'b0;
      mouse_left = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      tv[0] = '{12'd100,  12'd700,  12'd100,  12'd536};
      tv[1] = '{12'd0,    12'd0,    12'd0,    12'd0};
      tv[2] = '{12'd4095, 12'd4095, 12'd4095, 12'd536};
      tv[3] = '{12'd5,    12'd535,  12'd5,    12'd535};
      tv[4] = '{12'd6,    12'd536,  12'd6,    12'd536};
      tv[5] = '{12'd7,    12'd537,  12'd7,    12'd536};
      tv[6] = '{12'd2000, 12'd300,  12'd2000, 12'd300};
      tv[7] = '{12'd639,  12'd1,    12'd639,  12'd1};

      mouse_xpos = 12'd321;
      mouse_ypos = 12'd123;
      do_reset();
      rst = 1'b1;
      step();
      check("reset_x", xpos, 12'd0);
      check("reset_y", ypos, 12'd0);
      check("reset_busy", {11'd0, busy}, 12'd0);
      rst = 1'b0;

      // Tracking with floor clamp
      for (int i = 0; i < 8; i++) begin
         mouse_xpos = tv[i].mx;
         mouse_ypos = tv[i].my;
         step();
         check($sformatf("track_x[%0d]", i), xpos, tv[i].ex);
         check($sformatf("track_y[%0d]", i), ypos, tv[i].ey);
         check($sformatf("track_busy[%0d]", i), {11'd0, busy}, 12'd0);
      end

      // Free fall, bounce, rise, apex
      do_reset();
      mouse_xpos = 12'd100;
      mouse_ypos = 12'd0;
      step();
      mouse_left = 1'b1;
      step();
      check("drop_busy", {11'd0, busy}, 12'd1);
      check("drop_y", ypos, 12'd0);
      mouse_left = 1'b0;
      mouse_xpos = 12'd300;
      mouse_ypos = 12'd400;
      step();
      for (int n = 1; n <= 32; n++) begin
         do_tick();
         check($sformatf("fall_y[%0d]", n), ypos, 12'(n * (n + 1) / 2));
         if (n == 5) begin
            do_click();
            check("fall_click_y", ypos, 12'd15);
            check("fall_click_busy", {11'd0, busy}, 12'd1);
         end
      end
      check("fall_x_frozen", xpos, 12'd100);
      do_tick();
      check("impact_y", ypos, 12'd536);
      check("impact_busy", {11'd0, busy}, 12'd1);
      do_click();
      check("rise_click_y", ypos, 12'd536);
      do_tick();
      check("rise_y1", ypos, 12'd511);
      do_tick();
      check("rise_y2", ypos, 12'd487);
      for (int k = 0; k < 22; k++) do_tick();
      check("apex_y", ypos, 12'd212);
      do_tick();
      check("apex_turn_y", ypos, 12'd212);
      check("apex_turn_busy", {11'd0, busy}, 12'd1);
      for (int k = 0; k < 24; k++) do_tick();
      check("refall_y", ypos, 12'd512);
      do_tick();
      check("rebound_y", ypos, 12'd536);
      do_tick();
      check("rebound_rise_y", ypos, 12'd517);
      check("bounce_x_frozen", xpos, 12'd100);

      // Click and tick together in TRACK
      do_reset();
      mouse_xpos = 12'd100;
      mouse_ypos = 12'd50;
      step();
      check("sim_track_y", ypos, 12'd50);
      mouse_ypos = 12'd300;
      mouse_left = 1'b1;
      vsync_in   = 1'b1;
      step();
      check("sim_y", ypos, 12'd50);
      check("sim_x", xpos, 12'd100);
      check("sim_busy", {11'd0, busy}, 12'd1);
      mouse_left = 1'b0;
      vsync_in   = 1'b0;
      step();
      check("sim_hold_y", ypos, 12'd50);
      do_tick();
      check("sim_first_drop", ypos, 12'd51);

      // Reset mid-fall with inputs held high through release
      do_reset();
      mouse_xpos = 12'd100;
      mouse_ypos = 12'd0;
      step();
      do_click();
      for (int k = 0; k < 10; k++) do_tick();
      check("rst_pre_y", ypos, 12'd55);
      vsync_in   = 1'b1;
      mouse_left = 1'b1;
      rst        = 1'b1;
      step();
      check("rst_mid_x", xpos, 12'd0);
      check("rst_mid_y", ypos, 12'd0);
      check("rst_mid_busy", {11'd0, busy}, 12'd0);
      step();
      mouse_xpos = 12'd200;
      mouse_ypos = 12'd100;
      rst = 1'b0;
      step();
      check("rel_x", xpos, 12'd200);
      check("rel_y", ypos, 12'd100);
      check("rel_busy", {11'd0, busy}, 12'd0);
      mouse_xpos = 12'd210;
      mouse_ypos = 12'd120;
      step();
      step();
      check("rel_track_y", ypos, 12'd120);
      check("rel_track_busy", {11'd0, busy}, 12'd0);
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      check("rel_click_busy", {11'd0, busy}, 12'd1);
      mouse_left = 1'b0;
      step();
      step();
      check("rel_no_tick_y", ypos, 12'd120);
      vsync_in = 1'b0;
      step();
      do_tick();
      check("rel_tick_y", ypos, 12'd121);

      // Rebound at exactly VMIN keeps bouncing
      do_reset();
      mouse_xpos = 12'd40;
      mouse_ypos = 12'd534;
      step();
      do_click();
      do_tick();
      check("vmin_y1", ypos, 12'd535);
      do_tick();
      check("vmin_y2", ypos, 12'd536);
      check("vmin_busy", {11'd0, busy}, 12'd1);
      do_tick();
      check("vmin_rise_y", ypos, 12'd534);

      // Rebound below VMIN stops; STOP holds, click restarts tracking
      do_reset();
      mouse_xpos = 12'd70;
      mouse_ypos = 12'd535;
      step();
      do_click();
      mouse_xpos = 12'd900;
      mouse_ypos = 12'd10;
      do_tick();
      check("stop_y", ypos, 12'd536);
      check("stop_x", xpos, 12'd70);
      check("stop_busy", {11'd0, busy}, 12'd0);
      do_tick();
      check("stop_hold_y", ypos, 12'd536);
      mouse_left = 1'b1;
      step();
      check("restart_hold_x", xpos, 12'd70);
      check("restart_hold_y", ypos, 12'd536);
      mouse_left = 1'b0;
      step();
      check("restart_x", xpos, 12'd900);
      check("restart_y", ypos, 12'd10);
      check("restart_busy", {11'd0, busy}, 12'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
